// File: rtl/sha256_multiblock.sv
// Streaming multi-block SHA-256 over a word-addressed memory. The padding is generated on the fly.
// Define SHA256_MIDSTATE_EN to add resume-from-midstate inputs.
module sha256_multiblock #(
  parameter int NUM_OF_WORDS = 20,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
`ifdef SHA256_MIDSTATE_EN
  input  logic              use_midstate,
  input  logic [255:0]      midstate,
  input  logic [15:0]       prior_blocks,
`endif
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);
  localparam int          NB       = (NUM_OF_WORDS + 18) / 16;
  localparam logic [11:0] LAST_BLK = 12'(NB - 1);
  localparam logic [15:0] N_W      = 16'(NUM_OF_WORDS);
  localparam logic [63:0] MSG_BITS = 64'(NUM_OF_WORDS) * 64'd32;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [31:0] IV_TAB [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_UPDATE, S_WRITE} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t              state_q, state_d;
  logic [6:0]          cnt_q, cnt_d;
  logic [11:0]         blk_q, blk_d;
  logic [ADDR_W-1:0]   msg_base_q, msg_base_d, out_base_q, out_base_d;
  logic [63:0]         len_q, len_d;
  logic [31:0]         h_q [8], h_d [8];
  logic [31:0]         wv_q [8], wv_d [8];
  logic [31:0]         w_q [16], w_d [16];
  logic                mem_we_q, mem_we_d, done_q, done_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [15:0]         idx_cur_s, nxt_idx_s, nblk_idx_s;
  logic [31:0]         stream_s, t1_s, t2_s, w_new_s;

  // Stream word index being captured (read issued one cycle earlier), the next read, and the next block start.
  assign idx_cur_s  = {blk_q, 4'(cnt_q - 7'd1)};
  assign nxt_idx_s  = {blk_q, 4'd0} + 16'(cnt_q) + 16'd1;
  assign nblk_idx_s = {blk_q + 12'd1, 4'd0};

  assign t1_s = wv_q[7] + (rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25))
              + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6])) + K_TAB[cnt_q[5:0]] + w_q[0];
  assign t2_s = (rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22))
              + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
  assign w_new_s = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
                 + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];

  always_comb begin
    if (idx_cur_s < N_W) stream_s = mem_read_data;
    else if (idx_cur_s == N_W) stream_s = 32'h8000_0000;
    else if (blk_q == LAST_BLK && idx_cur_s[3:0] == 4'd14) stream_s = len_q[63:32];
    else if (blk_q == LAST_BLK && idx_cur_s[3:0] == 4'd15) stream_s = len_q[31:0];
    else stream_s = 32'h0;
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; blk_d = blk_q;
    msg_base_d = msg_base_q; out_base_d = out_base_q; len_d = len_q;
    h_d = h_q; wv_d = wv_q; w_d = w_q;
    mem_we_d = 1'b0; mem_addr_d = mem_addr_q; mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD; cnt_d = 7'd0; blk_d = 12'd0;
          msg_base_d = message_addr; out_base_d = output_addr; mem_addr_d = message_addr;
`ifdef SHA256_MIDSTATE_EN
          if (use_midstate) begin
            for (int i = 0; i < 8; i++) h_d[i] = midstate[32*(7-i) +: 32];
            len_d = MSG_BITS + (64'(prior_blocks) << 9);
          end else begin
            h_d = IV_TAB; len_d = MSG_BITS;
          end
`else
          h_d = IV_TAB; len_d = MSG_BITS;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q != 7'd0) begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = stream_s;
        end else begin
          w_d = w_q;
        end
        // Padding words are synthesised locally, so the address is only advanced for real message words.
        if (cnt_q < 7'd15 && nxt_idx_s < N_W) mem_addr_d = msg_base_q + ADDR_W'(nxt_idx_s);
        else mem_addr_d = mem_addr_q;
        if (cnt_q == 7'd16) begin
          state_d = S_COMPUTE; cnt_d = 7'd0; wv_d = h_q;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_COMPUTE: begin
        wv_d[0] = t1_s + t2_s; wv_d[1] = wv_q[0]; wv_d[2] = wv_q[1]; wv_d[3] = wv_q[2];
        wv_d[4] = wv_q[3] + t1_s; wv_d[5] = wv_q[4]; wv_d[6] = wv_q[5]; wv_d[7] = wv_q[6];
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_new_s;
        if (cnt_q == 7'd63) begin
          state_d = S_UPDATE; cnt_d = 7'd0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_UPDATE: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + wv_q[i];
        if (blk_q == LAST_BLK) begin
          // Outputs are registered, so the first digest write is staged on the way into WRITE.
          state_d = S_WRITE; cnt_d = 7'd0; mem_we_d = 1'b1;
          mem_addr_d = out_base_q; mem_wdata_d = h_q[0] + wv_q[0];
        end else begin
          state_d = S_LOAD; cnt_d = 7'd0; blk_d = blk_q + 12'd1;
          if (nblk_idx_s < N_W) mem_addr_d = msg_base_q + ADDR_W'(nblk_idx_s);
          else mem_addr_d = mem_addr_q;
        end
      end
      S_WRITE: begin
        if (cnt_q == 7'd7) begin
          state_d = S_IDLE; cnt_d = 7'd0;
        end else begin
          cnt_d = cnt_q + 7'd1; mem_we_d = 1'b1;
          mem_addr_d = out_base_q + ADDR_W'(cnt_q + 7'd1);
          mem_wdata_d = h_q[cnt_q[2:0] + 3'd1];
        end
      end
      default: begin
        state_d = S_IDLE; cnt_d = 7'd0;
      end
    endcase
    done_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE; cnt_q <= 7'd0; blk_q <= 12'd0;
      msg_base_q <= '0; out_base_q <= '0; len_q <= 64'd0;
      for (int i = 0; i < 8; i++) begin h_q[i] <= 32'd0; wv_q[i] <= 32'd0; end
      for (int i = 0; i < 16; i++) w_q[i] <= 32'd0;
      mem_we_q <= 1'b0; mem_addr_q <= '0; mem_wdata_q <= 32'd0; done_q <= 1'b1;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; blk_q <= blk_d;
      msg_base_q <= msg_base_d; out_base_q <= out_base_d; len_q <= len_d;
      h_q <= h_d; wv_q <= wv_d; w_q <= w_d;
      mem_we_q <= mem_we_d; mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d; done_q <= done_d;
    end
  end

  assign done           = done_q;
  assign mem_clk        = clk;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
endmodule

// File: tb/tb_sha256_multiblock.sv
// Scoreboard bench: five instances (N = 1, 13, 14, 16, 20), each with its own word memory,
// compared against a software SHA-256 model.
module tb_sha256_multiblock;
  localparam int NI = 5;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV_P  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABCD_P = 256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589;

  function automatic int nv(input int i);
    case (i)
      0: return 1;
      1: return 13;
      2: return 14;
      3: return 16;
      default: return 20;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] msg_addr, out_addr;
  logic        start_v [NI];
  logic        done_v [NI], we_v [NI], mclk_v [NI];
  logic [15:0] addr_v [NI];
  logic [31:0] wdata_v [NI], rdata_v [NI];
  logic [31:0] mem [NI][256];
  logic [31:0] msg_w [32];
  logic [47:0] exp_q [$], obs_q [$];
  int total = 0, bad = 0, lat20 = 0;
`ifdef SHA256_MIDSTATE_EN
  logic        use_mid = 1'b0;
  logic [255:0] mid_v = 256'd0;
  logic [15:0] prior_v = 16'd0;
`endif

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int AW = (gi == 4) ? 16 : 8;
    logic [AW-1:0] ma;
    sha256_multiblock #(.NUM_OF_WORDS(nv(gi)), .ADDR_W(AW)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start_v[gi]),
      .message_addr(msg_addr[AW-1:0]), .output_addr(out_addr[AW-1:0]),
`ifdef SHA256_MIDSTATE_EN
      .use_midstate(use_mid), .midstate(mid_v), .prior_blocks(prior_v),
`endif
      .done(done_v[gi]), .mem_clk(mclk_v[gi]), .mem_we(we_v[gi]), .mem_addr(ma),
      .mem_write_data(wdata_v[gi]), .mem_read_data(rdata_v[gi]));
    assign addr_v[gi] = 16'(ma);
  end

  // Synchronous-read memories: data for the address presented one cycle earlier.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) rdata_v[i] <= mem[i][addr_v[i][7:0]];
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: pads the whole message up front, then runs the textbook 64-entry schedule per block.
  function automatic logic [255:0] model(input int n, input logic [255:0] ivp, input int len_bits);
    logic [31:0] p [$];
    logic [31:0] w [64];
    logic [31:0] hv [8];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < n; i++) p.push_back(msg_w[i]);
    p.push_back(32'h8000_0000);
    while ((p.size() % 16) != 14) p.push_back(32'h0);
    p.push_back(32'h0);
    p.push_back(32'(len_bits));
    for (int i = 0; i < 8; i++) hv[i] = ivp[32*(7-i) +: 32];
    for (int blk = 0; blk < p.size() / 16; blk++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) w[t] = p[blk*16 + t];
        else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                  + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      end
      a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3]; e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d; hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    end
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  endfunction

  task automatic load_msg(input int idx, input logic [15:0] base);
    for (int i = 0; i < nv(idx); i++) mem[idx][8'(base + 16'(i))] = msg_w[i];
  endtask

  task automatic push_exp(input int idx, input logic [15:0] oa, input logic [255:0] dig);
    logic [15:0] mask;
    mask = (idx == 4) ? 16'hFFFF : 16'h00FF;
    for (int k = 0; k < 8; k++) exp_q.push_back({(oa + 16'(k)) & mask, dig[32*(7-k) +: 32]});
  endtask

  // Drives one start and collects writes; counts reads outside [base, base+N) while busy.
  task automatic drive_run(input int idx, input bit hold, input int poke_at, input logic [15:0] base,
                           output int lat, output int nwr, output int rdbad, output bit tmo);
    int cyc;
    logic [15:0] mask, off;
    mask = (idx == 4) ? 16'hFFFF : 16'h00FF;
    nwr = 0; rdbad = 0;
    start_v[idx] = 1'b1;
    @(negedge clk);
    if (!hold) start_v[idx] = 1'b0;
    cyc = 1;
    while (done_v[idx] !== 1'b1 && cyc < 2000) begin
      if (we_v[idx] === 1'b1) begin
        obs_q.push_back({addr_v[idx], wdata_v[idx]});
        nwr++;
      end else begin
        off = (addr_v[idx] - base) & mask;
        if (int'(off) >= nv(idx)) rdbad++;
      end
      if (cyc == poke_at) begin
        start_v[idx] = 1'b1; msg_addr = 16'h0100; out_addr = 16'h0200;
      end else if (cyc == poke_at + 1) begin
        start_v[idx] = hold;
      end
      @(negedge clk);
      cyc++;
    end
    tmo = (done_v[idx] !== 1'b1);
    lat = cyc - 1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (done_v[4] !== 1'b1) begin bad++; $display("FAIL rst_done got=%b want=1", done_v[4]); end
    total++; if (we_v[4] !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", we_v[4]); end
    total++; if (addr_v[4] !== 16'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", addr_v[4]); end
    total++; if (wdata_v[4] !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h want=0", wdata_v[4]); end
    total++; if (mclk_v[4] !== clk) begin bad++; $display("FAIL mem_clk got=%b want=%b", mclk_v[4], clk); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (done_v[0] !== 1'b1) begin bad++; $display("FAIL idle_done got=%b want=1", done_v[0]); end
  endtask

  task automatic test_abcd();
    int lat, nwr, rdbad; bit tmo; logic [47:0] e, g;
    exp_q.delete(); obs_q.delete();
    msg_addr = 16'h0010; out_addr = 16'h0040;
    mem[0][8'h10] = 32'h61626364;
    push_exp(0, out_addr, ABCD_P);
    drive_run(0, 1'b0, -1, 16'h0010, lat, nwr, rdbad, tmo);
    total++; if (tmo) begin bad++; $display("FAIL abcd_timeout got=%0d cycles want=done", lat); end
    total++; if (nwr != 8) begin bad++; $display("FAIL abcd_nwr got=%0d want=8", nwr); end
    total++; if (lat > 96) begin bad++; $display("FAIL abcd_latency got=%0d want<=96", lat); end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front(); g = 48'hx;
      if (obs_q.size() > 0) g = obs_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL abcd_wr%0d got=%h want=%h", k, g, e); end
    end
  endtask

  task automatic test_multiblock();
    int lat, nwr, rdbad; bit tmo; logic [47:0] e, g;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 20; i++) msg_w[i] = $urandom;
    msg_addr = 16'hFFF0; out_addr = 16'h1234;
    load_msg(4, msg_addr);
    push_exp(4, out_addr, model(20, IV_P, 640));
    drive_run(4, 1'b0, -1, 16'hFFF0, lat, nwr, rdbad, tmo);
    lat20 = lat;
    total++; if (tmo) begin bad++; $display("FAIL mb_timeout got=%0d cycles want=done", lat); end
    total++; if (nwr != 8) begin bad++; $display("FAIL mb_nwr got=%0d want=8", nwr); end
    total++; if (rdbad != 0) begin bad++; $display("FAIL mb_reads got=%0d bad reads want=0", rdbad); end
    total++; if (lat > 180) begin bad++; $display("FAIL mb_latency got=%0d want<=180", lat); end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front(); g = 48'hx;
      if (obs_q.size() > 0) g = obs_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL mb_wr%0d got=%h want=%h", k, g, e); end
    end
  endtask

  task automatic test_boundary();
    int lat, nwr, rdbad, bmax; bit tmo; logic [47:0] e, g;
    for (int idx = 1; idx <= 3; idx++) begin
      exp_q.delete(); obs_q.delete();
      for (int i = 0; i < nv(idx); i++) msg_w[i] = $urandom;
      msg_addr = 16'h00F8; out_addr = 16'h0080;
      load_msg(idx, msg_addr);
      push_exp(idx, out_addr, model(nv(idx), IV_P, 32 * nv(idx)));
      bmax = 84 * ((idx == 1) ? 1 : 2) + 12;
      drive_run(idx, 1'b0, -1, 16'h00F8, lat, nwr, rdbad, tmo);
      total++; if (tmo || lat > bmax) begin bad++; $display("FAIL bnd%0d_latency got=%0d want<=%0d", nv(idx), lat, bmax); end
      total++; if (rdbad != 0) begin bad++; $display("FAIL bnd%0d_reads got=%0d want=0", nv(idx), rdbad); end
      total++; if (nwr != 8) begin bad++; $display("FAIL bnd%0d_nwr got=%0d want=8", nv(idx), nwr); end
      for (int k = 0; k < 8; k++) begin
        e = exp_q.pop_front(); g = 48'hx;
        if (obs_q.size() > 0) g = obs_q.pop_front();
        total++; if (g !== e) begin bad++; $display("FAIL bnd%0d_wr%0d got=%h want=%h", nv(idx), k, g, e); end
      end
    end
  endtask

  task automatic test_ignore_start();
    int lat, nwr, rdbad; bit tmo; logic [47:0] e, g;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 20; i++) msg_w[i] = $urandom;
    msg_addr = 16'hFFF0; out_addr = 16'h1234;
    load_msg(4, msg_addr);
    push_exp(4, 16'h1234, model(20, IV_P, 640));
    drive_run(4, 1'b0, 40, 16'hFFF0, lat, nwr, rdbad, tmo);
    total++; if (tmo || lat != lat20) begin bad++; $display("FAIL ign_latency got=%0d want=%0d", lat, lat20); end
    total++; if (rdbad != 0) begin bad++; $display("FAIL ign_reads got=%0d want=0", rdbad); end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front(); g = 48'hx;
      if (obs_q.size() > 0) g = obs_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL ign_wr%0d got=%h want=%h", k, g, e); end
    end
    msg_addr = 16'hFFF0; out_addr = 16'h1234;
  endtask

  task automatic test_reset_mid();
    int lat, nwr, rdbad, stray; bit tmo; logic [47:0] e, g;
    exp_q.delete(); obs_q.delete();
    start_v[4] = 1'b1;
    @(negedge clk);
    start_v[4] = 1'b0;
    repeat (50) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++; if (done_v[4] !== 1'b1) begin bad++; $display("FAIL rmid_done got=%b want=1", done_v[4]); end
    total++; if (we_v[4] !== 1'b0) begin bad++; $display("FAIL rmid_we got=%b want=0", we_v[4]); end
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (we_v[4] !== 1'b0 || done_v[4] !== 1'b1) stray++;
    end
    total++; if (stray != 0) begin bad++; $display("FAIL rmid_abort got=%0d active cycles want=0", stray); end
    push_exp(4, out_addr, model(20, IV_P, 640));
    drive_run(4, 1'b0, -1, msg_addr, lat, nwr, rdbad, tmo);
    total++; if (tmo || nwr != 8) begin bad++; $display("FAIL rmid_nwr got=%0d want=8", nwr); end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front(); g = 48'hx;
      if (obs_q.size() > 0) g = obs_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL rmid_wr%0d got=%h want=%h", k, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, nwr1, nwr2, rd1, rd2; bit tmo1, tmo2; logic [47:0] e, g;
    exp_q.delete(); obs_q.delete();
    push_exp(4, out_addr, model(20, IV_P, 640));
    push_exp(4, out_addr, model(20, IV_P, 640));
    drive_run(4, 1'b1, -1, msg_addr, lat1, nwr1, rd1, tmo1);
    drive_run(4, 1'b1, -1, msg_addr, lat2, nwr2, rd2, tmo2);
    start_v[4] = 1'b0;
    total++; if (tmo1 || tmo2 || lat1 != lat20 || lat2 != lat20) begin
      bad++; $display("FAIL b2b_latency got=%0d,%0d want=%0d", lat1, lat2, lat20);
    end
    total++; if (nwr1 + nwr2 != 16) begin bad++; $display("FAIL b2b_nwr got=%0d want=16", nwr1 + nwr2); end
    for (int k = 0; k < 16; k++) begin
      e = exp_q.pop_front(); g = 48'hx;
      if (obs_q.size() > 0) g = obs_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL b2b_wr%0d got=%h want=%h", k, g, e); end
    end
    @(negedge clk);
    total++; if (done_v[4] !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b want=1", done_v[4]); end
  endtask

`ifdef SHA256_MIDSTATE_EN
  task automatic test_midstate();
    int lat, nwr, rdbad; bit tmo; logic [47:0] e, g;
    exp_q.delete(); obs_q.delete();
    use_mid = 1'b1; mid_v = IV_P; prior_v = 16'd0;
    push_exp(4, out_addr, model(20, IV_P, 640));
    drive_run(4, 1'b0, -1, msg_addr, lat, nwr, rdbad, tmo);
    use_mid = 1'b0;
    total++; if (tmo || nwr != 8) begin bad++; $display("FAIL mid_nwr got=%0d want=8", nwr); end
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front(); g = 48'hx;
      if (obs_q.size() > 0) g = obs_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL mid_wr%0d got=%h want=%h", k, g, e); end
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      for (int j = 0; j < 256; j++) mem[i][j] = 32'h0;
    end
    msg_addr = 16'h0; out_addr = 16'h0;
    test_reset();
    test_abcd();
    test_multiblock();
    test_boundary();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef SHA256_MIDSTATE_EN
    test_midstate();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha256_multiblock.md
SHA256_MULTIBLOCK -- requirements
Module: sha256_multiblock

Interface
REQ-001 SHALL have parameter NUM_OF_WORDS, default 20, message length in 32-bit words, legal range 1..4096.
REQ-002 SHALL have parameter ADDR_W, default 16, width of all address ports.
REQ-003 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have start  input  1  begin hash; sampled only in IDLE.
REQ-006 SHALL have message_addr  input  ADDR_W  base address of message word 0.
REQ-007 SHALL have output_addr  input  ADDR_W  base address of digest word H0.
REQ-008 SHALL have done  output  1  high exactly while in IDLE.
REQ-009 SHALL have mem_clk  output  1  equal to clk.
REQ-010 SHALL have mem_we  output  1  write strobe.
REQ-011 SHALL have mem_addr  output  ADDR_W  memory address.
REQ-012 SHALL have mem_write_data  output  32  write data.
REQ-013 SHALL have mem_read_data  input  32  read data for the address presented one cycle earlier.

Function
REQ-014 SHALL hash NUM_OF_WORDS words per FIPS 180-4 SHA-256, big-endian words, message length L = 32*NUM_OF_WORDS bits.
REQ-015 SHALL process B = ceil((NUM_OF_WORDS+3)/16) blocks; no whole-message buffer, only a 16-word schedule window.
REQ-016 SHALL generate padding on the fly: stream word j<N = memory; j==N = 32'h80000000; last block words 14/15 = 0 / L[31:0]; all others 0.
REQ-017 SHALL read memory only for j<N; padding words SHALL not issue reads.
REQ-018 SHALL use states IDLE, LOAD, COMPUTE, UPDATE, WRITE; IDLE->LOAD on start; LOAD (16 schedule words)->COMPUTE; COMPUTE (64 rounds, rolling 16-word window)->UPDATE; UPDATE->LOAD if blocks remain, else WRITE; WRITE->IDLE after 8 writes.
REQ-019 SHALL latch message_addr and output_addr at start acceptance; later changes SHALL have no effect.
REQ-020 SHALL initialise H0..H7 to FIPS IV at start acceptance (midstate exception: REQ-031).
REQ-021 UPDATE SHALL add working variables a..h into H0..H7 modulo 2^32.
REQ-022 WRITE SHALL drive mem_we=1 for exactly 8 consecutive cycles, writing H0..H7 to output_addr+0..+7 in order; mem_we=0 in all other states.
REQ-023 SHALL ignore start outside IDLE; start held high in IDLE after completion SHALL begin a new hash next cycle.
REQ-024 Start-to-done latency SHALL be at most 84*B+12 cycles and identical for every run with equal B.
REQ-025 Address arithmetic SHALL wrap modulo 2^ADDR_W.
REQ-026 Boundary NUM_OF_WORDS%16 in {14,15} SHALL add an all-padding final block; ==13 SHALL fit in one block tail.

Reset
REQ-027 reset_n low SHALL asynchronously force IDLE, done=1, mem_we=0, mem_addr=0, mem_write_data=0, round/word counters 0.
REQ-028 Reset mid-LOAD/COMPUTE/WRITE SHALL abort; no further writes; partial digest discarded.

Configuration
REQ-029 Macro SHA256_MIDSTATE_EN SHALL select midstate support.
REQ-030 Without it SHALL have no extra ports and always start from IV.
REQ-031 With it SHALL add inputs use_midstate (1), midstate (256, H0 in MSBs), prior_blocks (16); when use_midstate=1 at start, H0..H7 load from midstate and L = 32*N + 512*prior_blocks (64-bit length, high word used).

Verification
REQ-032 N=1, word 32'h61626364 ("abcd") -> digest 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589 at output_addr..+7.
REQ-033 N=20, random data -> digest matches software model; B=2; exactly 8 mem_we cycles.
REQ-034 N=13, 14, 16 -> B=1, 2, 2; digests match model; no reads at address >= message_addr+N.
REQ-035 start pulsed during COMPUTE and output_addr changed mid-run -> ignored; writes at original output_addr.
REQ-036 reset_n low mid-COMPUTE -> done=1, mem_we=0 immediately; following start yields correct digest.
REQ-037 SHA256_MIDSTATE_EN, use_midstate=1, midstate=IV, prior_blocks=0 -> digest identical to use_midstate=0.
